bus_master_port: RTL and testbench

- Local-side command interface that turns one parallel read/write request into a serial bus transaction addressed to a slave, for example the 4k memory slave.
- Handles the bus-request/grant handshake, then drives bus_util, rd_wrt and data_bus_serial.
- For reads, releases the bus and deserializes the slave's reply.
- Sits directly upstream of every slave on the serial bus, between a processor/test controller and the arbiter/bus.

---
 rtl/bus_master_pkg.sv | 24 ++
 rtl/bus_master_port_shifter.sv | 44 ++++
 rtl/bus_master_port.sv | 221 ++++++++++++++++++++++
 tb/tb_bus_master_port.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_master_pkg.sv
// Shared state encoding, bus direction constants and helpers for the serial bus master port.
package bus_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SEND_ID,
        SEND_ADDR,
        SEND_DATA,
        WAIT_RD,
        RECV_DATA,
        DONE
    } state_t;

    localparam logic BUS_WRITE = 1'b1;
    localparam logic BUS_READ  = 1'b0;

    localparam int DEFAULT_ID_WIDTH = 3;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bus_master_port_shifter.sv
// Loadable MSB-first shift register usable as PISO (ser_out) or SIPO (par_out),
// with a remaining-bit down-counter whose done flag marks the last shift.
module serial_shifter #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    input  logic             shift,
    input  logic             ser_in,
    output logic             ser_out,
    output logic [WIDTH-1:0] par_out,
    output logic             done
);

    logic [WIDTH-1:0] sr;
    logic [LEN_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (load) begin
            sr <= load_data;
        end else if (shift) begin
            sr <= {sr[WIDTH-2:0], ser_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_len;
        end else if (shift && (remaining != '0)) begin
            remaining <= remaining - 1'b1;
        end
    end

    assign ser_out = sr[WIDTH-1];
    assign par_out = sr;
    assign done    = (remaining == LEN_W'(1));

endmodule

// File: rtl/bus_master_port.sv
// Serial bus master: accepts one parallel command, arbitrates for the bus, shifts out
// ID/address/data MSB-first and, for reads, waits for a start bit and shifts the reply in.
module bus_master_port
    import bus_master_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 15,
    parameter int DATA_WIDTH    = 8,
    parameter int ID_WIDTH      = DEFAULT_ID_WIDTH,
    parameter int RD_TIMEOUT    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_rd_wrt,
    input  logic [ID_WIDTH-1:0]      cmd_slave_id,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_timeout,
    output logic                     bus_req,
    input  logic                     bus_grant,
    output logic                     bus_util,
    output logic                     rd_wrt,
    input  logic                     slave_busy,
    inout  wire                      data_bus_serial
);

    localparam int TX_W     = max_of(max_of(ID_WIDTH, ADDRESS_WIDTH), DATA_WIDTH);
    localparam int TX_LEN_W = $clog2(TX_W + 1);
    localparam int RX_LEN_W = $clog2(DATA_WIDTH + 1);
    localparam int CNT_W    = $clog2(max_of(max_of(ADDRESS_WIDTH, DATA_WIDTH), RD_TIMEOUT));

    state_t                   state, state_next;
    logic                     dir_q;
    logic [ID_WIDTH-1:0]      id_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [CNT_W-1:0]         bit_cnt;
    logic                     timeout_q;
    logic [DATA_WIDTH-1:0]    rdata_q;

    logic                     tx_load, tx_shift, tx_drive, tx_ser, tx_done;
    logic [TX_W-1:0]          tx_load_data;
    logic [TX_LEN_W-1:0]      tx_load_len;
    logic [TX_W-1:0]          tx_par_unused;
    logic                     rx_load, rx_shift, rx_done;
    logic [DATA_WIDTH-1:0]    rx_par;
    logic                     rx_ser_unused;
    logic                     line_one;

    // X/Z on the line compares as not-1, so it never counts as a start bit.
    assign line_one        = (data_bus_serial == 1'b1);
    assign data_bus_serial = tx_drive ? tx_ser : 1'bz;

    serial_shifter #(.WIDTH(TX_W), .LEN_W(TX_LEN_W)) u_tx (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_load),
        .load_data(tx_load_data),
        .load_len (tx_load_len),
        .shift    (tx_shift),
        .ser_in   (1'b0),
        .ser_out  (tx_ser),
        .par_out  (tx_par_unused),
        .done     (tx_done)
    );

    serial_shifter #(.WIDTH(DATA_WIDTH), .LEN_W(RX_LEN_W)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .load     (rx_load),
        .load_data('0),
        .load_len (RX_LEN_W'(DATA_WIDTH)),
        .shift    (rx_shift),
        .ser_in   (line_one),
        .ser_out  (rx_ser_unused),
        .par_out  (rx_par),
        .done     (rx_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        rsp_valid  = 1'b0;
        bus_req    = 1'b0;
        bus_util   = 1'b0;
        rd_wrt     = 1'b0;
        tx_drive   = 1'b0;
        tx_shift   = 1'b0;
        rx_shift   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_next = REQ;
            end
            REQ: begin
                bus_req = 1'b1;
                if (bus_grant) state_next = SEND_ID;
            end
            SEND_ID, SEND_ADDR, SEND_DATA: begin
                bus_req  = 1'b1;
                bus_util = 1'b1;
                rd_wrt   = dir_q;
                tx_drive = 1'b1;
                tx_shift = 1'b1;
                if (tx_done) begin
                    if (state == SEND_ID)       state_next = SEND_ADDR;
                    else if (state == SEND_DATA) state_next = DONE;
                    else if (dir_q == BUS_READ)  state_next = WAIT_RD;
                    else                         state_next = SEND_DATA;
                end
            end
            WAIT_RD: begin
                bus_req  = 1'b1;
                bus_util = 1'b1;
                rd_wrt   = dir_q;
                if (line_one)                                state_next = RECV_DATA;
                else if (bit_cnt == CNT_W'(RD_TIMEOUT - 1)) state_next = DONE;
            end
            RECV_DATA: begin
                bus_req  = 1'b1;
                bus_util = 1'b1;
                rd_wrt   = dir_q;
                rx_shift = 1'b1;
                if (rx_done) state_next = DONE;
            end
            DONE: begin
                rsp_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Shifters are loaded on the edge that enters the state that consumes them.
    always_comb begin
        tx_load      = 1'b0;
        tx_load_data = '0;
        tx_load_len  = '0;
        rx_load      = 1'b0;
        if (state_next != state) begin
            case (state_next)
                SEND_ID: begin
                    tx_load      = 1'b1;
                    tx_load_data = TX_W'(id_q) << (TX_W - ID_WIDTH);
                    tx_load_len  = TX_LEN_W'(ID_WIDTH);
                end
                SEND_ADDR: begin
                    tx_load      = 1'b1;
                    tx_load_data = TX_W'(addr_q) << (TX_W - ADDRESS_WIDTH);
                    tx_load_len  = TX_LEN_W'(ADDRESS_WIDTH);
                end
                SEND_DATA: begin
                    tx_load      = 1'b1;
                    tx_load_data = TX_W'(wdata_q) << (TX_W - DATA_WIDTH);
                    tx_load_len  = TX_LEN_W'(DATA_WIDTH);
                end
                RECV_DATA: rx_load = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cmd_valid) begin
            dir_q   <= cmd_rd_wrt;
            id_q    <= cmd_slave_id;
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
        end
    end

    // A busy slave is still working on the request, so the read timeout pauses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt <= '0;
        end else if (state_next != state) begin
            bit_cnt <= '0;
        end else if (!(state == WAIT_RD && slave_busy) && (bit_cnt != '1)) begin
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (state == WAIT_RD && state_next == DONE) begin
            timeout_q <= 1'b1;
        end else if (state == IDLE) begin
            timeout_q <= 1'b0;
        end
    end

    always_comb begin
        rsp_rdata = rdata_q;
        if (state == DONE && dir_q == BUS_READ) begin
            rsp_rdata = timeout_q ? '0 : rx_par;
        end
    end

    assign rsp_timeout = (state == DONE) && timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (state == DONE) begin
            rdata_q <= rsp_rdata;
        end
    end

endmodule

// File: tb/tb_bus_master_port.sv
// Scoreboard bench for bus_master_port: directed commands push expected line bits and
// responses; a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_bus_master_port;

    localparam int AW = 15;
    localparam int DW = 8;
    localparam int IW = 3;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_rd_wrt;
    logic [IW-1:0] cmd_slave_id;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_timeout;
    logic          bus_req;
    logic          bus_grant;
    logic          bus_util;
    logic          rd_wrt;
    logic          slave_busy;
    wire           data_bus_serial;
    logic          drv_en;
    logic          drv_val;

    assign data_bus_serial = drv_en ? drv_val : 1'bz;

    always #5 clk = ~clk;

    bus_master_port #(
        .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .RD_TIMEOUT(TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_rd_wrt     (cmd_rd_wrt),
        .cmd_slave_id   (cmd_slave_id),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_timeout    (rsp_timeout),
        .bus_req        (bus_req),
        .bus_grant      (bus_grant),
        .bus_util       (bus_util),
        .rd_wrt         (rd_wrt),
        .slave_busy     (slave_busy),
        .data_bus_serial(data_bus_serial)
    );

    typedef struct packed { logic bit_v; logic dir; } bit_exp_t;
    typedef struct packed { logic is_rd; logic to; logic [DW-1:0] rdata; } rsp_exp_t;

    bit_exp_t bit_q[$];
    rsp_exp_t rsp_q[$];
    bit_exp_t mb;
    rsp_exp_t mr;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic dir, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input logic to, input logic [DW-1:0] rd);
        for (int i = IW - 1; i >= 0; i--) bit_q.push_back({id[i], dir});
        for (int i = AW - 1; i >= 0; i--) bit_q.push_back({addr[i], dir});
        if (dir) begin
            for (int i = DW - 1; i >= 0; i--) bit_q.push_back({wd[i], dir});
        end
        rsp_q.push_back({~dir, to, rd});
    endtask

    task automatic issue(input logic dir, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd);
        int n = 0;
        cmd_rd_wrt   = dir;
        cmd_slave_id = id;
        cmd_addr     = addr;
        cmd_wdata    = wd;
        cmd_valid    = 1'b1;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("issue_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Returns at the start of cycle G+1.
    task automatic give_grant(input int delay);
        int n = 0;
        while (!bus_req && n < 50) begin
            tick();
            n++;
        end
        check("req_seen", bus_req, 1);
        repeat (delay) tick();
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 0);
        check({tag, "_rsp_timeout"}, rsp_timeout, 0);
        check({tag, "_bus_req"}, bus_req, 0);
        check({tag, "_bus_util"}, bus_util, 0);
        check({tag, "_rd_wrt"}, rd_wrt, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus_util && bit_q.size() != 0) begin
                mb = bit_q.pop_front();
                check("line_bit", data_bus_serial, mb.bit_v);
                check("line_rd_wrt", rd_wrt, mb.dir);
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, expected 0 (t=%0t)", $time);
                end else begin
                    mr = rsp_q.pop_front();
                    check("rsp_timeout", rsp_timeout, mr.to);
                    if (mr.is_rd) check("rsp_rdata", rsp_rdata, mr.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] pat;
        rst = 1'b1; cmd_valid = 1'b0; cmd_rd_wrt = 1'b0; cmd_slave_id = '0; cmd_addr = '0;
        cmd_wdata = '0; bus_grant = 1'b0; slave_busy = 1'b0; drv_en = 1'b0; drv_val = 1'b0;
        tick();
        @(negedge clk);
        check_reset_outputs("reset");
        tick();
        rst = 1'b0;

        // Write: id 1, addr 0123, data A5
        push_cmd(1'b1, 3'd1, 15'h0123, 8'hA5, 1'b0, 8'h00);
        issue(1'b1, 3'd1, 15'h0123, 8'hA5);
        give_grant(2);
        repeat (25) tick();
        @(negedge clk);
        check("wr_no_early_rsp", rsp_valid, 0);
        check("wr_util_g26", bus_util, 1);
        tick();
        @(negedge clk);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_timeout", rsp_timeout, 0);
        check("wr_util_done", bus_util, 0);
        check("wr_rdwrt_done", rd_wrt, 0);
        check("wr_req_done", bus_req, 0);
        tick();
        @(negedge clk);
        check("wr_ready_back", cmd_ready, 1);

        // Read timeout: nobody answers
        push_cmd(1'b0, 3'd2, 15'h0055, 8'h00, 1'b1, 8'h00);
        issue(1'b0, 3'd2, 15'h0055, 8'h00);
        give_grant(0);
        repeat (81) tick();
        @(negedge clk);
        check("to_no_early_rsp", rsp_valid, 0);
        check("to_util_wait", bus_util, 1);
        tick();
        @(negedge clk);
        check("to_rsp_valid", rsp_valid, 1);
        check("to_rsp_timeout", rsp_timeout, 1);
        check("to_rsp_rdata", rsp_rdata, 0);
        tick();
        @(negedge clk);
        check("to_util_after", bus_util, 0);
        tick();

        // Grant delay with a second command held pending
        push_cmd(1'b1, 3'd5, 15'h4000, 8'h3C, 1'b0, 8'h00);
        push_cmd(1'b1, 3'd6, 15'h0001, 8'hFF, 1'b0, 8'h00);
        cmd_rd_wrt = 1'b1; cmd_slave_id = 3'd5; cmd_addr = 15'h4000; cmd_wdata = 8'h3C;
        cmd_valid = 1'b1;
        tick();
        cmd_slave_id = 3'd6; cmd_addr = 15'h0001; cmd_wdata = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_req", bus_req, 1);
            check("bp_util", bus_util, 0);
            check("bp_ready", cmd_ready, 0);
            tick();
        end
        bus_grant = 1'b1;
        tick();
        bus_grant = 1'b0;
        repeat (26) tick();
        @(negedge clk);
        check("bp_rsp1", rsp_valid, 1);
        check("bp_ready_done", cmd_ready, 0);
        tick();
        @(negedge clk);
        check("bp_ready_idle", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_second_req", bus_req, 1);
        check("bp_second_busy", cmd_ready, 0);
        give_grant(0);
        repeat (26) tick();
        @(negedge clk);
        check("bp_rsp2", rsp_valid, 1);
        tick();

        // Read: slave replies 5 cycles into WAIT_RD with 3C
        push_cmd(1'b0, 3'd0, 15'h7FFF, 8'h00, 1'b0, 8'h3C);
        issue(1'b0, 3'd0, 15'h7FFF, 8'h00);
        give_grant(0);
        repeat (23) tick();
        drv_en = 1'b1;
        drv_val = 1'b1;
        @(negedge clk);
        check("rd_wait_util", bus_util, 1);
        check("rd_wait_dir", rd_wrt, 0);
        pat = 8'h3C;
        for (int i = DW - 1; i >= 0; i--) begin
            tick();
            drv_val = pat[i];
        end
        tick();
        drv_en = 1'b0;
        @(negedge clk);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 8'h3C);
        check("rd_rsp_timeout", rsp_timeout, 0);
        tick();

        // Reset during the address phase
        push_cmd(1'b1, 3'd7, 15'h2AAA, 8'h81, 1'b0, 8'h00);
        issue(1'b1, 3'd7, 15'h2AAA, 8'h81);
        give_grant(0);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bit_q.delete();
        rsp_q.delete();
        @(negedge clk);
        check_reset_outputs("rst_mid");
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check("rst_mid_no_rsp", rsp_valid, 0);
        end
        tick();

        // Fresh write after the aborted one
        push_cmd(1'b1, 3'd4, 15'h1357, 8'h5A, 1'b0, 8'h00);
        issue(1'b1, 3'd4, 15'h1357, 8'h5A);
        give_grant(1);
        repeat (26) tick();
        @(negedge clk);
        check("fresh_rsp_valid", rsp_valid, 1);
        tick();
        tick();

        check("bits_drained", bit_q.size(), 0);
        check("rsps_drained", rsp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
